e_muldiv: RTL and testbench
===========================

Name: e_muldiv

Overview:
- Execute-stage multiply/divide unit. It consumes the D->E pipeline register outputs (IR_E, RS_E, RT_E), runs mult/multu/div/divu over multiple cycles, owns the HI/LO registers, and serves mthi/mtlo/mfhi/mflo.
- Drives Start/Busy back to the hazard unit, which asserts the D->E Stall for any HI/LO-touching instruction in D while Start||Busy.
- Honors an M-stage exception/interrupt cancel so that a victim instruction never commits HI/LO state.

Parameters:
MULT_CYCLES, 5, Busy duration in cycles for mult/multu
DIV_CYCLES, 10, Busy duration in cycles for div/divu

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; clears all state
IR_E  input  32  instruction in E stage
RS_E  input  32  forwarded rs operand
RT_E  input  32  forwarded rt operand
Cancel  input  1  exception/interrupt taken this cycle; suppresses start and mthi/mtlo
Start  output  1  combinational; a mult/div begins at this edge
Busy  output  1  registered; operation in flight
HI  output  32  HI register
LO  output  32  LO register
MDOut  output  32  combinational mfhi/mflo result

Behaviour:
- Decode: op==6'b000000 with funct mult=011000, multu=011001, div=011010, divu=011011, mfhi=010000, mthi=010001, mflo=010010, mtlo=010011. All other IR_E values (including 0 / bubble) are NOPs for this block.
- Reset (reset==0, asynchronous): HI=0, LO=0, Busy=0, counter=0, pending results=0. Any in-flight operation is discarded.
- Start = isMulDiv(IR_E) && !Busy && !Cancel.
- FSM states:
  - IDLE (Busy=0) -> RUN on Start: load counter with MULT_CYCLES or DIV_CYCLES; latch computed pending_hi/pending_lo from RS_E/RT_E at that edge.
  - RUN (Busy=1): counter decrements each edge. On the edge where counter==1: HI<=pending_hi, LO<=pending_lo, Busy<=0 -> IDLE.
  - Busy is therefore high for exactly N cycles after the start edge. New HI/LO are visible in the first cycle Busy is low.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend (RS). 0x80000000/0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned.
  - Divide by zero: the op still runs the full DIV_CYCLES with Busy, but HI/LO are left unchanged at completion.
- mthi/mtlo: HI/LO<=RS_E at the edge when !Busy && !Cancel. Ignored while Busy (the hazard unit guarantees a stall). Ignored when Cancel.
- mfhi/mflo: MDOut=HI/LO (current register value, combinational). Otherwise MDOut=0.
- Cancel during RUN does not abort: the in-flight op completes and commits.
- Cancel in the same cycle as a would-be start: no start, Busy stays 0, HI/LO unchanged.
- A mult/div in E while Busy (only possible on stall failure) is ignored. The in-flight op is unaffected.
- Back-to-back ops: a new Start is legal in the first cycle Busy==0. That edge commits nothing new to HI/LO (the previous op committed already).

Test Plan:
1. Reset low mid-RUN (2 cycles into div) -> Busy=0, HI=0, LO=0 immediately, without waiting for a clock edge. After release, mfhi gives MDOut=0.
2. mult RS=0xFFFFFFFE (-2), RT=3 -> Start=1 for one cycle. Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. A multu with the same operands gives HI=0x00000002, LO=0xFFFFFFFA.
3. div RS=0xFFFFFFF9 (-7), RT=2 -> Busy for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 after mthi 0x1234 -> Busy for 10 cycles, HI remains 0x1234.
4. mult presented with Cancel=1 -> Start=0, Busy stays 0, HI/LO unchanged. mtlo RS=0xABCD with Cancel=1 -> LO unchanged. Without Cancel -> LO=0xABCD, and mflo gives MDOut=0xABCD.
5. mult issued, then Cancel asserted on cycle 3 of RUN -> operation still completes at cycle 5 and HI/LO update.
6. Boundary: div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0. A mult issued in the first cycle Busy==0 -> Start=1 and the new result commits 5 cycles later.

Source files
------------

// File: rtl/e_muldiv.sv
// Execute-stage multiply/divide unit: owns HI/LO, runs mult/div for a fixed
// number of cycles, and serves mthi/mtlo/mfhi/mflo.
module e_muldiv #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] IR_E,
  input  logic [31:0] RS_E,
  input  logic [31:0] RT_E,
  input  logic        Cancel,
  output logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut,
  output logic        dbg_state
);

  // Handshake: Start is a one-cycle pulse (valid) qualified by !Busy (ready)
  // and !Cancel; the hazard unit holds HI/LO users in D while Start||Busy.

  localparam int MAXC = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic            pend_we_q, pend_we_d;

  logic            special;
  logic            is_mult, is_multu, is_div, is_divu;
  logic            is_mfhi, is_mthi, is_mflo, is_mtlo, is_muldiv;
  logic            unused_ir;

  logic signed [63:0] prod_s;
  logic [63:0]     prod_u;
  logic [31:0]     abs_s, abs_t, dvs_s, dvs_u;
  logic [31:0]     uq, ur, q_s, r_s, q_u, r_u;
  logic [31:0]     res_hi, res_lo;

  assign unused_ir = ^IR_E[25:6];

  always_comb begin
    special   = (IR_E[31:26] == 6'b000000);
    is_mult   = special && (IR_E[5:0] == F_MULT);
    is_multu  = special && (IR_E[5:0] == F_MULTU);
    is_div    = special && (IR_E[5:0] == F_DIV);
    is_divu   = special && (IR_E[5:0] == F_DIVU);
    is_mfhi   = special && (IR_E[5:0] == F_MFHI);
    is_mthi   = special && (IR_E[5:0] == F_MTHI);
    is_mflo   = special && (IR_E[5:0] == F_MFLO);
    is_mtlo   = special && (IR_E[5:0] == F_MTLO);
    is_muldiv = is_mult || is_multu || is_div || is_divu;
  end

  // Signed divide works on magnitudes so that 0x80000000 / -1 wraps cleanly.
  always_comb begin
    prod_s = $signed({{32{RS_E[31]}}, RS_E}) * $signed({{32{RT_E[31]}}, RT_E});
    prod_u = {32'd0, RS_E} * {32'd0, RT_E};
    abs_s  = RS_E[31] ? (32'd0 - RS_E) : RS_E;
    abs_t  = RT_E[31] ? (32'd0 - RT_E) : RT_E;
    dvs_s  = (abs_t == 32'd0) ? 32'd1 : abs_t;
    dvs_u  = (RT_E == 32'd0) ? 32'd1 : RT_E;
    uq     = abs_s / dvs_s;
    ur     = abs_s % dvs_s;
    q_s    = (RS_E[31] ^ RT_E[31]) ? (32'd0 - uq) : uq;
    r_s    = RS_E[31] ? (32'd0 - ur) : ur;
    q_u    = RS_E / dvs_u;
    r_u    = RS_E % dvs_u;
    res_hi = 32'd0;
    res_lo = 32'd0;
    if (is_mult) begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end else if (is_multu) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else if (is_div) begin
      res_hi = r_s;
      res_lo = q_s;
    end else if (is_divu) begin
      res_hi = r_u;
      res_lo = q_u;
    end
  end

  assign Busy      = (state_q == RUN);
  assign Start     = is_muldiv && !Busy && !Cancel;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign dbg_state = state_q;

  always_comb begin
    MDOut = 32'd0;
    if (is_mfhi) MDOut = hi_q;
    else if (is_mflo) MDOut = lo_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d   = RUN;
          cnt_d     = (is_mult || is_multu) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
          pend_hi_d = res_hi;
          pend_lo_d = res_lo;
          // Divide by zero still occupies the unit but must not commit.
          pend_we_d = !((is_div || is_divu) && (RT_E == 32'd0));
        end else if (!Cancel) begin
          if (is_mthi) hi_d = RS_E;
          if (is_mtlo) lo_d = RS_E;
        end
      end
      RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pend_we_d = 1'b0;
          if (pend_we_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

endmodule

// File: tb/tb_e_muldiv.sv
// Randomized and directed bench for e_muldiv against a 64-bit arithmetic
// reference model with an expected-result queue.
module tb_e_muldiv;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] IR_E, RS_E, RT_E;
  logic        Cancel;
  logic        Start, Busy, dbg_state;
  logic [31:0] HI, LO, MDOut;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] exp_q[$];
  logic [31:0] m_hi, m_lo;

  e_muldiv #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .IR_E(IR_E), .RS_E(RS_E), .RT_E(RT_E),
    .Cancel(Cancel), .Start(Start), .Busy(Busy), .HI(HI), .LO(LO),
    .MDOut(MDOut), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference: {HI, LO} after the op completes, from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_result(input logic [5:0] f, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [31:0] chi,
                                             input logic [31:0] clo);
    longint a, b, q, r;
    logic [63:0] res;
    res = {chi, clo};
    case (f)
      6'h18: begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        res = a * b;
      end
      6'h19: res = {32'd0, rs} * {32'd0, rt};
      6'h1a: if (rt != 0) begin
        a = longint'($signed(rs));
        b = longint'($signed(rt));
        q = a / b;
        r = a % b;
        res = {r[31:0], q[31:0]};
      end
      6'h1b: if (rt != 0) res = {rs % rt, rs / rt};
      default: res = {chi, clo};
    endcase
    return res;
  endfunction

  // Precondition: called just after a falling edge with the unit idle.
  task automatic do_op(input logic [5:0] f, input logic [31:0] rs, input logic [31:0] rt,
                       input bit cancel, input int cancel_cyc);
    logic [63:0] exp_r;
    bit          is_md, starts, done;
    int          cyc;
    IR_E   = {26'd0, f};
    RS_E   = rs;
    RT_E   = rt;
    Cancel = cancel;
    #1;
    is_md  = (f == 6'h18) || (f == 6'h19) || (f == 6'h1a) || (f == 6'h1b);
    starts = is_md && !cancel;
    check("start", {31'd0, Start}, {31'd0, starts});
    if (f == 6'h10)      check("mdout_hi", MDOut, m_hi);
    else if (f == 6'h12) check("mdout_lo", MDOut, m_lo);
    else                 check("mdout_zero", MDOut, 32'd0);
    if (starts) exp_q.push_back(ref_result(f, rs, rt, m_hi, m_lo));
    @(posedge clk);
    #1;
    if (!cancel) begin
      if (f == 6'h11) m_hi = rs;
      if (f == 6'h13) m_lo = rs;
    end
    IR_E   = 32'd0;
    Cancel = 1'b0;
    if (starts) begin
      cyc  = 0;
      done = 1'b0;
      while (!done && cyc < 100) begin
        @(negedge clk);
        if (!Busy) begin
          done = 1'b1;
        end else begin
          cyc++;
          IR_E   = 32'd0;
          RS_E   = $urandom;
          RT_E   = $urandom;
          Cancel = (cyc == cancel_cyc);
          if (cyc == 2) IR_E = {26'd0, 6'h11};
          if (cyc == 3) begin
            IR_E = {26'd0, 6'h18};
            #1;
            check("start_while_busy", {31'd0, Start}, 32'd0);
          end
        end
      end
      IR_E   = 32'd0;
      Cancel = 1'b0;
      check("busy_cycles", cyc, ((f == 6'h18) || (f == 6'h19)) ? MULT_N : DIV_N);
      if (exp_q.size() > 0) begin
        exp_r = exp_q.pop_front();
        m_hi  = exp_r[63:32];
        m_lo  = exp_r[31:0];
      end
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end else begin
      @(negedge clk);
      check("busy_idle", {31'd0, Busy}, 32'd0);
      check("hi", HI, m_hi);
      check("lo", LO, m_lo);
    end
  endtask

  logic [5:0] fsel[10];

  initial begin
    fsel = '{6'h18, 6'h19, 6'h1a, 6'h1b, 6'h10, 6'h11, 6'h12, 6'h13, 6'h00, 6'h20};
    reset  = 1'b0;
    IR_E   = 32'd0;
    RS_E   = 32'd0;
    RT_E   = 32'd0;
    Cancel = 1'b0;
    m_hi   = 32'd0;
    m_lo   = 32'd0;
    #1;
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset in the middle of a divide.
    do_op(6'h11, 32'h55, 32'd0, 1'b0, 0);
    do_op(6'h13, 32'h66, 32'd0, 1'b0, 0);
    IR_E = {26'd0, 6'h1a};
    RS_E = 32'd100;
    RT_E = 32'd7;
    #1;
    check("rst_test_start", {31'd0, Start}, 32'd1);
    @(posedge clk);
    #1;
    IR_E = 32'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("pre_rst_busy", {31'd0, Busy}, 32'd1);
    check("pre_rst_hi", HI, 32'h55);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_busy", {31'd0, Busy}, 32'd0);
    check("async_rst_hi", HI, 32'd0);
    check("async_rst_lo", LO, 32'd0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    do_op(6'h10, 32'd0, 32'd0, 1'b0, 0);

    // Directed arithmetic.
    do_op(6'h18, 32'hFFFFFFFE, 32'd3, 1'b0, 0);
    check("mult_hi_const", HI, 32'hFFFFFFFF);
    check("mult_lo_const", LO, 32'hFFFFFFFA);
    do_op(6'h19, 32'hFFFFFFFE, 32'd3, 1'b0, 0);
    check("multu_hi_const", HI, 32'h00000002);
    check("multu_lo_const", LO, 32'hFFFFFFFA);
    do_op(6'h1a, 32'hFFFFFFF9, 32'd2, 1'b0, 0);
    check("div_lo_const", LO, 32'hFFFFFFFD);
    check("div_hi_const", HI, 32'hFFFFFFFF);
    do_op(6'h11, 32'h1234, 32'd0, 1'b0, 0);
    do_op(6'h1b, 32'd7, 32'd0, 1'b0, 0);
    check("divu0_hi_const", HI, 32'h1234);

    // Cancel suppression.
    do_op(6'h18, 32'd5, 32'd6, 1'b1, 0);
    do_op(6'h13, 32'hABCD, 32'd0, 1'b1, 0);
    do_op(6'h13, 32'hABCD, 32'd0, 1'b0, 0);
    do_op(6'h12, 32'd0, 32'd0, 1'b0, 0);
    check("mflo_const", LO, 32'hABCD);

    // Cancel during RUN does not abort.
    do_op(6'h18, 32'd1000, 32'd77, 1'b0, 3);
    check("cancel_run_lo", LO, 32'd77000);

    // Overflow divide followed immediately by a back-to-back mult.
    do_op(6'h1a, 32'h80000000, 32'hFFFFFFFF, 1'b0, 0);
    check("ovf_lo_const", LO, 32'h80000000);
    check("ovf_hi_const", HI, 32'd0);
    do_op(6'h18, 32'd9, 32'd11, 1'b0, 0);
    check("b2b_lo_const", LO, 32'd99);

    // Randomized mix.
    for (int i = 0; i < 30; i++) begin
      logic [31:0] rs, rt;
      rs = $urandom;
      rt = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rs = 32'h80000000;
      if ($urandom_range(0, 3) == 0) rt = 32'hFFFFFFFF;
      do_op(fsel[$urandom_range(0, 9)], rs, rt, ($urandom_range(0, 4) == 0), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
